// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the up/down sweep sequencer.
package sweep_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int DWELL_W_DEF = 8;
  localparam int REP_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISE,
    ST_HOLD_HI,
    ST_FALL,
    ST_HOLD_LO
  } state_t;

endpackage

// File: rtl/updown_counter_core.sv
// Plain WIDTH-bit up/down counter with synchronous load; load wins over count enable.
module updown_counter_core #(
  parameter int WIDTH = sweep_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);
  import sweep_pkg::*;

  // Counter register: load, else step up or down when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= down ? count - WIDTH'(1) : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-wave sweep sequencer driving an up/down counter between two bounds.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a command; count holds its last value
// ST_RISE    | stepping up toward hi; arrival at hi is the first hi cycle
// ST_HOLD_HI | remaining d cycles parked at hi
// ST_FALL    | stepping down toward lo; arrival at lo is the first lo cycle
// ST_HOLD_LO | remaining d cycles parked at lo; last one ends the period
module updown_sweep_ctrl #(
  parameter int WIDTH   = sweep_pkg::WIDTH_DEF,
  parameter int DWELL_W = sweep_pkg::DWELL_W_DEF,
  parameter int REP_W   = sweep_pkg::REP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_lo,
  input  logic [WIDTH-1:0]   cmd_hi,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic [REP_W-1:0]   cmd_reps,
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic               down,
  output logic               busy,
  output logic               done,
  output logic               err
);
  import sweep_pkg::*;

  state_t             state, state_next;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt;
  logic [REP_W-1:0]   reps_q, period_cnt;

  logic             ctr_en, ctr_down, ctr_load;
  logic [WIDTH-1:0] ctr_load_val;
  logic             latch, dwell_load, dwell_dec, period_inc, period_clr, period_end;
  logic             done_next, err_next;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ctr_en),
    .down     (ctr_down),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .count    (count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and counter/timer controls; abort overrides everything while busy.
  always_comb begin
    state_next   = state;
    ctr_en       = 1'b0;
    ctr_down     = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_val = lo_q;
    latch        = 1'b0;
    dwell_load   = 1'b0;
    dwell_dec    = 1'b0;
    period_inc   = 1'b0;
    period_clr   = 1'b0;
    period_end   = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_lo >= cmd_hi) begin
            err_next = 1'b1;
          end else begin
            latch        = 1'b1;
            ctr_load     = 1'b1;
            ctr_load_val = cmd_lo;
            period_clr   = 1'b1;
            state_next   = ST_RISE;
          end
        end
      end
      ST_RISE: begin
        if (count != hi_q) begin
          ctr_en = 1'b1;
        end else if (dwell_q == '0) begin
          ctr_en     = 1'b1;
          ctr_down   = 1'b1;
          state_next = ST_FALL;
        end else begin
          dwell_load = 1'b1;
          state_next = ST_HOLD_HI;
        end
      end
      ST_HOLD_HI: begin
        if (dwell_cnt == '0) begin
          ctr_en     = 1'b1;
          ctr_down   = 1'b1;
          state_next = ST_FALL;
        end else begin
          dwell_dec = 1'b1;
        end
      end
      ST_FALL: begin
        if (count != lo_q) begin
          ctr_en   = 1'b1;
          ctr_down = 1'b1;
        end else if (dwell_q == '0) begin
          period_end = 1'b1;
        end else begin
          dwell_load = 1'b1;
          state_next = ST_HOLD_LO;
        end
      end
      ST_HOLD_LO: begin
        if (dwell_cnt == '0) period_end = 1'b1;
        else                 dwell_dec  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    // Period boundary: finish, or restart the climb one above lo (lo was just shown).
    if (period_end) begin
      period_inc = 1'b1;
      if (reps_q != '0 && (period_cnt + REP_W'(1)) == reps_q) begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end else begin
        ctr_load     = 1'b1;
        ctr_load_val = lo_q + WIDTH'(1);
        state_next   = ST_RISE;
      end
    end

    if (state != ST_IDLE && abort) begin
      state_next = ST_IDLE;
      ctr_en     = 1'b0;
      ctr_load   = 1'b0;
      dwell_load = 1'b0;
      dwell_dec  = 1'b0;
      period_inc = 1'b0;
      done_next  = 1'b0;
    end
  end

  // Command fields, dwell down-counter, period counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q       <= '0;
      hi_q       <= '0;
      dwell_q    <= '0;
      reps_q     <= '0;
      dwell_cnt  <= '0;
      period_cnt <= '0;
      down       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (latch) begin
        lo_q    <= cmd_lo;
        hi_q    <= cmd_hi;
        dwell_q <= cmd_dwell;
        reps_q  <= cmd_reps;
      end
      if (dwell_load)     dwell_cnt <= dwell_q - DWELL_W'(1);
      else if (dwell_dec) dwell_cnt <= dwell_cnt - DWELL_W'(1);
      if (period_clr)      period_cnt <= '0;
      else if (period_inc) period_cnt <= period_cnt + REP_W'(1);
      down <= (state_next == ST_FALL) || (state_next == ST_HOLD_LO);
      done <= done_next;
      err  <= err_next;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Randomized bench for updown_sweep_ctrl against a list-based triangle-wave model.
`timescale 1ns/1ps
module tb_updown_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_lo = '0, cmd_hi = '0;
  logic [7:0]  cmd_dwell = '0;
  logic [15:0] cmd_reps = '0;
  logic        abort = 1'b0;
  logic [31:0] count;
  logic        down, busy, done, err;

  updown_sweep_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_lo    (cmd_lo),
    .cmd_hi    (cmd_hi),
    .cmd_dwell (cmd_dwell),
    .cmd_reps  (cmd_reps),
    .abort     (abort),
    .count     (count),
    .down      (down),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_count = '0;

  typedef struct {
    logic [31:0] c;
    logic        dn;
  } smp_t;
  smp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected per-cycle (count, down) for a sweep; N=0 is modelled for three periods.
  task automatic build(input logic [31:0] lo, input logic [31:0] hi, input int d, input int n);
    int periods;
    smp_t s;
    exp_q.delete();
    periods = (n == 0) ? 3 : n;
    for (int p = 0; p < periods; p++) begin
      longint start_v;
      start_v = (p == 0) ? longint'(lo) : longint'(lo) + 1;
      for (longint v = start_v; v < longint'(hi); v++) begin
        s.c = v[31:0]; s.dn = 1'b0; exp_q.push_back(s);
      end
      for (int k = 0; k <= d; k++) begin
        s.c = hi; s.dn = 1'b0; exp_q.push_back(s);
      end
      for (longint v = longint'(hi) - 1; v > longint'(lo); v--) begin
        s.c = v[31:0]; s.dn = 1'b1; exp_q.push_back(s);
      end
      for (int k = 0; k <= d; k++) begin
        s.c = lo; s.dn = 1'b1; exp_q.push_back(s);
      end
    end
  endtask

  task automatic start(input logic [31:0] lo, input logic [31:0] hi, input int d, input int n);
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_done", done, 0);
    cmd_valid = 1'b1;
    cmd_lo    = lo;
    cmd_hi    = hi;
    cmd_dwell = d[7:0];
    cmd_reps  = n[15:0];
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Checks from the first busy cycle; abort_at < 0 means run to completion.
  task automatic check_stream(input logic [31:0] lo, input logic [31:0] hi, input int d,
                              input int n, input int abort_at);
    build(lo, hi, d, n);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk("count", count, exp_q[i].c);
      chk("down", down, exp_q[i].dn);
      chk("busy", busy, 1);
      chk("ready_busy", cmd_ready, 0);
      chk("done_early", done, 0);
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_count", count, exp_q[i].c);
        chk("abort_down", down, 0);
        chk("abort_done", done, 0);
        model_count = exp_q[i].c;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        return;
      end
    end
    if (n == 0) return;
    @(negedge clk);
    chk("done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_count", count, lo);
    chk("end_ready", cmd_ready, 1);
    chk("end_down", down, 0);
    model_count = lo;
  endtask

  task automatic reject(input logic [31:0] lo, input logic [31:0] hi);
    start(lo, hi, 1, 1);
    @(negedge clk);
    chk("err", err, 1);
    chk("err_busy", busy, 0);
    chk("err_count", count, model_count);
    @(negedge clk);
    chk("err_once", err, 0);
    chk("err_busy2", busy, 0);
    chk("err_count2", count, model_count);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lo, hi;
    int d, n, len, kind;

    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_down", down, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    start(3, 5, 1, 1);
    check_stream(3, 5, 1, 1, -1);
    start(0, 2, 0, 2);
    check_stream(0, 2, 0, 2, -1);

    reject(5, 5);
    reject(7, 2);

    start(10, 12, 0, 0);
    check_stream(10, 12, 0, 0, 3);

    // Command held valid through a sweep is taken in the done cycle.
    start(20, 23, 2, 1);
    cmd_valid = 1'b1;
    cmd_lo    = 40;
    cmd_hi    = 42;
    cmd_dwell = 1;
    cmd_reps  = 1;
    check_stream(20, 23, 2, 1, -1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check_stream(40, 42, 1, 1, -1);

    start(32'hFFFF_FFFA, 32'hFFFF_FFFF, 1, 1);
    check_stream(32'hFFFF_FFFA, 32'hFFFF_FFFF, 1, 1, -1);

    // Reset in the middle of a climb.
    start(100, 200, 0, 1);
    repeat (3) @(negedge clk);
    chk("pre_rst_count", count, 102);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_down", down, 0);
    chk("arst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_count = '0;
    start(6, 9, 0, 1);
    check_stream(6, 9, 0, 1, -1);

    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(9, 0);
      if (kind < 2) begin
        lo = $urandom;
        hi = $urandom_range(lo, 0);
        reject(lo, hi);
      end else begin
        lo = $urandom_range(32'hFFFF_FFF0, 0);
        hi = lo + $urandom_range(6, 1);
        d  = $urandom_range(3, 0);
        if (kind == 2) begin
          n   = $urandom_range(3, 0);
          len = ((n == 0) ? 3 : n) * (2 * int'(hi - lo) + 2 * d) + 1;
          start(lo, hi, d, n);
          check_stream(lo, hi, d, n, $urandom_range(len - 1, 0));
        end else begin
          n = $urandom_range(3, 1);
          start(lo, hi, d, n);
          check_stream(lo, hi, d, n, -1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencer for the up/down counter datapath: accepts a sweep command (low bound, high bound, dwell, repetitions) and drives a WIDTH-bit up/down counter as a triangle wave between the bounds, holding at each turning point for a programmable dwell. It owns the counter's `down`/enable/load controls and exposes count, direction and status to downstream logic. It sits between a command source (test sequencer or CPU register block) and any consumer of the swept count.

## Interface
- `WIDTH`, 32, counter and bound width (unsigned)
- `DWELL_W`, 8, dwell field width
- `REP_W`, 16, repetition field width
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_lo`  in  WIDTH  low bound
- `cmd_hi`  in  WIDTH  high bound
- `cmd_dwell`  in  DWELL_W  extra hold cycles at each bound (d)
- `cmd_reps`  in  REP_W  full periods to run (N); 0 = run until abort
- `abort`  in  1  stop active sweep
- `count`  out  WIDTH  current counter value
- `down`  out  1  1 while descending or holding at lo
- `busy`  out  1  sweep active
- `done`  out  1  one-cycle pulse on normal completion
- `err`  out  1  one-cycle pulse on rejected command

## Operation
- States: IDLE, RISE, HOLD_HI, FALL, HOLD_LO. `cmd_ready` = (state == IDLE); `busy` = !IDLE.
- Reset values: state IDLE, `count`=0, `down`=0, `busy`=0, `done`=0, `err`=0, internal counters 0.
- Accept in IDLE: if `cmd_lo >= cmd_hi` (unsigned), pulse `err` next cycle, stay IDLE, `count` unchanged. Otherwise latch lo/hi/d/N, `count`<=lo, go RISE.
- RISE: `count` +1 per cycle until `count`==hi; that cycle no increment.
- hi visible for exactly d+1 consecutive cycles (including the arrival cycle), then FALL.
- FALL: `count` -1 per cycle until lo; lo visible for exactly d+1 cycles (HOLD_LO), `down`=1 throughout.
- End of HOLD_LO completes one period: if N≠0 and periods done == N, go IDLE, pulse `done`, `count` stays lo; else RISE (next value lo+1). N=0 never completes.
- `abort` (non-IDLE): next edge to IDLE, `count` frozen at current value, `down`<=0, no `done`. `abort` in IDLE ignored; `abort` with `cmd_valid` in IDLE: command accepted.
- Commands presented while busy are not accepted (backpressure, no drop).
- Arithmetic: unsigned, no wrap possible (lo<hi enforced); period counter REP_W bits, saturating not needed since terminal compare stops it.

## Timing
- Accept edge -> `count`=lo in the first busy cycle (latency 1).
- Count sequence, N=1: lo, lo+1 … hi (hi ×(d+1)), hi-1 … lo (lo ×(d+1)); busy cycles = N·(2(hi-lo)+2d)+1.
- `done` and `cmd_ready` both high in the first IDLE cycle after the last lo-hold cycle; back-to-back command may be accepted that cycle.
- `err` asserted in the cycle after the rejecting accept, one cycle only.
- `rst_n` low mid-sweep: all outputs to reset values immediately (asynchronous); first command accepted on first edge after release.
- All outputs registered except `cmd_ready`.

## Structure
- `sweep_pkg`: state enum, default parameter constants.
- Sub-module `updown_counter_core` (WIDTH; en, down, load, load_val -> count); the FSM, dwell counter and period counter live in `updown_sweep_ctrl`.

## Test plan
- lo=3, hi=5, d=1, N=1 -> count 3,4,5,5,4,3,3; then `done`=1 one cycle, count=3, busy 7 cycles.
- lo=0, hi=2, d=0, N=2 -> 0,1,2,1,0,1,2,1,0; `down`=1 exactly on the cycles showing 1(desc) and 0 after a 2; `done` once.
- lo=5, hi=5 then lo=7, hi=2 -> `err` pulse each, never busy, count unchanged.
- N=0, lo=10, hi=12, abort at count=11 on FALL -> IDLE next edge, count held 11, no `done`, new command accepted afterwards.
- cmd_valid held during sweep -> `cmd_ready`=0 until `done` cycle, second command accepted in that cycle, count jumps to its lo next cycle.
- rst_n low mid-RISE -> count=0, busy=0 immediately; after release, fresh command runs normally.
